hd44780_responder: RTL and testbench
====================================

# hd44780_responder

Synthesizable responder for the 8-bit HD44780 character-LCD bus driven by the board's LCD writer. It latches commands and data on the falling edge of the enable strobe, maintains a 2x16 DDRAM image, address counter, entry mode, display-control bits and busy flag. It answers busy/address and DDRAM reads, and exposes a character read port so a VGA text overlay can mirror the LCD contents. It sits beside the LCD pins: as an on-chip loopback target in simulation and hardware, and as the content source for the overlay.

## Interface
- BUSY_CYCLES, 2000: clk cycles busy after any non-clear command (40 us at 50 MHz).
- CLEAR_CYCLES, 82000: clk cycles busy after clear display (1.64 ms); must be ≥ 32.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset. Synchronous, active-high (fixed).
- lcd_en  in  1  HD44780 E strobe, asynchronous to clk.
- lcd_rs  in  1  0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_data_in  in  8  bus value from the writer.
- lcd_data_out  out  8  read-back value.
- lcd_data_oe  out  1  high while a read strobe is active.
- busy  out  1  busy flag.
- display_on, cursor_on, blink_on  out  1 each  display-control bits D/C/B.
- cursor_pos  out  5  visible cursor index 0–31; 31 when AC is off-screen.
- overrun  out  1  sticky; set when a strobe arrives while busy.
- rd_addr  in  5  overlay character index: row*16 + column.
- rd_char  out  8  DDRAM byte at rd_addr, one-cycle latency.

## Operation
- lcd_en, lcd_rs, lcd_rw and lcd_data_in all pass through a 2-FF synchronizer. A strobe is a 1→0 transition of the synchronized E. Fields are taken from the same synchronized stage.
- States:
  - S_IDLE: accepts strobes.
  - S_CLEAR: writes 0x20 into one cell per cycle, cells 0..31.
  - S_BUSY: counts down.
- A write strobe in S_IDLE with rs=0 is decoded on the highest set bit:
  - 1xxxxxxx: set AC = data[6:0].
  - 01xxxxxx: CGRAM address. Accepted; data writes are discarded until the next DDRAM address set.
  - 001xxxxx: function set. Stored, no effect.
  - 0001SRxx: if S=0, move the cursor right (R=1) or left; if S=1, display shift, ignored.
  - 00001DCB: load display_on, cursor_on, blink_on.
  - 000001IS: load I/D; S is ignored.
  - 0000001x: return home, AC = 0.
  - 00000001: clear. AC = 0, I/D = 1, go to S_CLEAR.
- All other commands go to S_BUSY loaded with BUSY_CYCLES−1.
- S_CLEAR takes 32 cycles, then enters S_BUSY with CLEAR_CYCLES−33.
- A write strobe with rs=1 stores data[7:0] at AC if AC is visible, then AC steps. Busy = BUSY_CYCLES.
- AC arithmetic is 7-bit on the HD44780 two-line map.
  - Increment wraps 0x27→0x40 and 0x67→0x00; decrement is the inverse.
  - Set-address values 0x28–0x3F map to 0x40 and 0x68–0x7F map to 0x00.
- Visible addresses: 0x00–0x0F map to cells 0–15; 0x40–0x4F map to cells 16–31.
- Writes to other addresses are discarded, but AC still steps.
- A strobe seen in S_CLEAR or S_BUSY is ignored and sets overrun.
- busy = (state ≠ S_IDLE).

## Timing
- Latency from the raw lcd_en falling edge to the state/AC/DDRAM update is 3 clk.
- Busy asserts on that same edge.
- Busy deasserts exactly BUSY_CYCLES clk after the update, or CLEAR_CYCLES for clear.
- Read port:
  - rd_char is registered, 1 cycle after rd_addr.
  - If the port and a protocol write hit the same cell in the same cycle, rd_char returns the old value.
- Reset values:
  - All DDRAM cells 0x20, AC 0x00, I/D 1, state S_IDLE.
  - busy, display_on, cursor_on, blink_on, overrun, lcd_data_oe: 0.
  - lcd_data_out 0x00, rd_char 0x00, cursor_pos 0.
- Reset mid-clear or mid-busy reaches the full reset state on the next edge.
- A strobe coincident with rst is dropped.

## Configuration
- HD44780_READ_EN defined (read path compiled in):
  - While synchronized E is high and rw=1, lcd_data_oe=1.
  - lcd_data_out = {busy, AC} for rs=0, or the DDRAM byte at AC for rs=1 (0x20 if off-screen).
  - A rs=1 read strobe steps AC.
  - Reads are served even while busy and never set overrun.
- HD44780_READ_EN undefined:
  - lcd_data_out = 0 and lcd_data_oe = 0 permanently.
  - Strobes with rw=1 are ignored entirely.

## Structure
- Package hd44780_pkg holds:
  - the state enum;
  - command decode masks;
  - SPACE_CHAR = 8'h20;
  - row base addresses 7'h00/7'h40 and wrap limits 7'h27/7'h67;
  - function ac_step(ac, inc) returning the next AC.
- Sub-module lcd_strobe_sync: 2-FF synchronizer on E/RS/RW/DATA. Outputs strobe_fall, en_high, and captured rs, rw, data.

## Test plan
Bench parameters: BUSY_CYCLES=8, CLEAR_CYCLES=40.
- Reset, then write 0x38, 0x0C, 0x06, 0x80, then data 'A','B': cells 0–1 = 0x41/0x42, AC = 0x02, display_on = 1, busy high for exactly 8 clk after each strobe.
- Clear (0x01) after filling cells: busy for 40 clk; rd_char returns 0x20 for all 32 cells; AC = 0.
- Set AC 0x0F, write two bytes: cell 15 written; AC steps to 0x10, then the write is discarded and AC = 0x11. Set AC 0x27 and write: AC → 0x40.
- Entry mode 0x04, set AC 0xC0, write: cell 16 written, AC wraps 0x40 → 0x27.
- Strobe 2 clk after a previous strobe: ignored, overrun = 1; assert rst mid-clear: next cycle busy = 0 and all cells = 0x20.
- READ_EN build: read rs=0 during busy → lcd_data_out = 0x80|AC, lcd_data_oe high; read rs=1 at AC 0x00 → 0x41, AC = 0x01.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared state type, command masks, DDRAM constants and address-counter helpers
// for the HD44780 bus responder.
package hd44780_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_BUSY  = 2'd2
   } state_e;

   localparam logic [7:0] SPACE_CHAR    = 8'h20;

   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
   localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
   localparam logic [7:0] CMD_SHIFT     = 8'h10;
   localparam logic [7:0] CMD_DISP_CTRL = 8'h08;
   localparam logic [7:0] CMD_ENTRY     = 8'h04;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;

   localparam logic [6:0] ROW0_BASE = 7'h00;
   localparam logic [6:0] ROW1_BASE = 7'h40;
   localparam logic [6:0] ROW0_LAST = 7'h27;
   localparam logic [6:0] ROW1_LAST = 7'h67;

   // Next AC on the two-line map; the rows chain into each other in both directions.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] nxt;
      if (inc) begin
         if (ac == ROW0_LAST)      nxt = ROW1_BASE;
         else if (ac == ROW1_LAST) nxt = ROW0_BASE;
         else                      nxt = ac + 7'd1;
      end else begin
         if (ac == ROW1_BASE)      nxt = ROW0_LAST;
         else if (ac == ROW0_BASE) nxt = ROW1_LAST;
         else                      nxt = ac - 7'd1;
      end
      return nxt;
   endfunction

   function automatic logic [6:0] ac_map(input logic [6:0] addr);
      logic [6:0] res;
      if (addr > ROW1_LAST)                           res = ROW0_BASE;
      else if ((addr > ROW0_LAST) && (addr < ROW1_BASE)) res = ROW1_BASE;
      else                                            res = addr;
      return res;
   endfunction

   // {visible, cell index}: 0x00-0x0F -> cells 0-15, 0x40-0x4F -> cells 16-31.
   function automatic logic [5:0] ac_cell(input logic [6:0] ac);
      logic vis;
      vis = (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
      return {vis, ac[6], ac[3:0]};
   endfunction

endpackage

// File: rtl/hd44780_responder_sync.sv
// Two-stage synchronizer for the asynchronous LCD bus (lcd_strobe_sync); all
// fields come from the same stage so they line up with the detected E fall.
module lcd_strobe_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_en,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data_in,
   output logic       strobe_fall,
   output logic       en_high,
   output logic       rs,
   output logic       rw,
   output logic [7:0] data
);
   logic [10:0] meta_q, meta_d, sync_q, sync_d;
   logic        en_prev_q, en_prev_d;

   always_comb begin
      meta_d    = {lcd_en, lcd_rs, lcd_rw, lcd_data_in};
      sync_d    = meta_q;
      en_prev_d = sync_q[10];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q    <= 11'd0;
         sync_q    <= 11'd0;
         en_prev_q <= 1'b0;
      end else begin
         meta_q    <= meta_d;
         sync_q    <= sync_d;
         en_prev_q <= en_prev_d;
      end
   end

   assign strobe_fall = en_prev_q & ~sync_q[10];
   assign en_high     = sync_q[10];
   assign rs          = sync_q[9];
   assign rw          = sync_q[8];
   assign data        = sync_q[7:0];

endmodule

// File: rtl/hd44780_responder.sv
// HD44780 8-bit bus responder with a 2x16 DDRAM image and an overlay read port.
// Define HD44780_READ_EN to compile in the busy/address and DDRAM read path.
module hd44780_responder
   import hd44780_pkg::*;
#(
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_en,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   output logic       busy,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic [4:0] cursor_pos,
   output logic       overrun,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char
);
   localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 33);
   // The 32 clearing cycles already cover a minimum-length clear.
   localparam state_e CLEAR_NEXT = (CLEAR_CYCLES > 32) ? S_BUSY : S_IDLE;

   logic       s_fall, s_en_high, s_rs, s_rw;
   logic [7:0] s_data;
   logic       wr_strobe;
   logic [5:0] acs, acn;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       clr_idx_q, clr_idx_d;
   logic [6:0]       ac_q, ac_d;
   logic             id_q, id_d, cgram_q, cgram_d;
   logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
   logic             overrun_q, overrun_d, busy_q, busy_d, oe_q, oe_d;
   logic [4:0]       cursor_pos_q, cursor_pos_d;
   logic [7:0]       rd_char_q, rd_char_d, data_out_q, data_out_d;
   logic [7:0]       ram_q [32];
   logic [7:0]       ram_d [32];

   lcd_strobe_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .lcd_en      (lcd_en),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_data_in (lcd_data_in),
      .strobe_fall (s_fall),
      .en_high     (s_en_high),
      .rs          (s_rs),
      .rw          (s_rw),
      .data        (s_data)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clr_idx_d = clr_idx_q;
      ac_d      = ac_q;
      id_d      = id_q;
      cgram_d   = cgram_q;
      disp_d    = disp_q;
      cur_d     = cur_q;
      blink_d   = blink_q;
      ram_d     = ram_q;
      wr_strobe = s_fall & ~s_rw;
      acs       = ac_cell(ac_q);

      case (state_q)
         S_IDLE: begin
            if (wr_strobe) begin
               state_d = S_BUSY;
               cnt_d   = BUSY_LOAD;
               if (s_rs) begin
                  if (acs[5] && !cgram_q) ram_d[acs[4:0]] = s_data;
                  else                    ram_d = ram_q;
                  ac_d = ac_step(ac_q, id_q);
               end else if ((s_data & CMD_SET_DDRAM) != 8'h00) begin
                  ac_d    = ac_map(s_data[6:0]);
                  cgram_d = 1'b0;
               end else if ((s_data & CMD_SET_CGRAM) != 8'h00) begin
                  cgram_d = 1'b1;
               end else if ((s_data & CMD_FUNC_SET) != 8'h00) begin
                  cgram_d = cgram_q;
               end else if ((s_data & CMD_SHIFT) != 8'h00) begin
                  if (!s_data[3]) ac_d = ac_step(ac_q, s_data[2]);
                  else            ac_d = ac_q;
               end else if ((s_data & CMD_DISP_CTRL) != 8'h00) begin
                  {disp_d, cur_d, blink_d} = s_data[2:0];
               end else if ((s_data & CMD_ENTRY) != 8'h00) begin
                  id_d = s_data[1];
               end else if ((s_data & CMD_HOME) != 8'h00) begin
                  ac_d = ROW0_BASE;
               end else if ((s_data & CMD_CLEAR) != 8'h00) begin
                  ac_d      = ROW0_BASE;
                  id_d      = 1'b1;
                  clr_idx_d = 5'd0;
                  state_d   = S_CLEAR;
               end else begin
                  state_d = S_BUSY;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            ram_d[clr_idx_q] = SPACE_CHAR;
            clr_idx_d        = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) begin
               state_d = CLEAR_NEXT;
               cnt_d   = CLEAR_LOAD;
            end else begin
               state_d = S_CLEAR;
            end
         end
         S_BUSY: begin
            if (cnt_q == {CNT_W{1'b0}}) state_d = S_IDLE;
            else                        cnt_d = cnt_q - CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      if (wr_strobe && (state_q != S_IDLE)) overrun_d = 1'b1;
      else                                  overrun_d = overrun_q;

`ifdef HD44780_READ_EN
      // Reads bypass the busy gate; a data read advances AC like a write.
      ac_d = (s_fall && s_rw && s_rs) ? ac_step(ac_q, id_q) : ac_d;
      oe_d = s_en_high & s_rw;
      if (!oe_d)     data_out_d = 8'h00;
      else if (s_rs) data_out_d = acs[5] ? ram_q[acs[4:0]] : SPACE_CHAR;
      else           data_out_d = {busy_q, ac_q};
`else
      oe_d       = s_en_high & s_rw & 1'b0;
      data_out_d = 8'h00;
`endif

      busy_d       = (state_d != S_IDLE);
      acn          = ac_cell(ac_d);
      cursor_pos_d = acn[5] ? acn[4:0] : 5'd31;
      rd_char_d    = ram_q[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         clr_idx_q    <= 5'd0;
         ac_q         <= ROW0_BASE;
         id_q         <= 1'b1;
         cgram_q      <= 1'b0;
         disp_q       <= 1'b0;
         cur_q        <= 1'b0;
         blink_q      <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
         oe_q         <= 1'b0;
         cursor_pos_q <= 5'd0;
         rd_char_q    <= 8'h00;
         data_out_q   <= 8'h00;
         for (int i = 0; i < 32; i++) ram_q[i] <= SPACE_CHAR;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clr_idx_q    <= clr_idx_d;
         ac_q         <= ac_d;
         id_q         <= id_d;
         cgram_q      <= cgram_d;
         disp_q       <= disp_d;
         cur_q        <= cur_d;
         blink_q      <= blink_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
         oe_q         <= oe_d;
         cursor_pos_q <= cursor_pos_d;
         rd_char_q    <= rd_char_d;
         data_out_q   <= data_out_d;
         ram_q        <= ram_d;
      end
   end

   assign lcd_data_out = data_out_q;
   assign lcd_data_oe  = oe_q;
   assign busy         = busy_q;
   assign display_on   = disp_q;
   assign cursor_on    = cur_q;
   assign blink_on     = blink_q;
   assign cursor_pos   = cursor_pos_q;
   assign overrun      = overrun_q;
   assign rd_char      = rd_char_q;

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed scoreboard bench for hd44780_responder (BUSY_CYCLES=8, CLEAR_CYCLES=40).
// Read-path steps are compiled when HD44780_READ_EN is defined.
`timescale 1ns/1ps
module tb_hd44780_responder;
   localparam int BUSY_N  = 8;
   localparam int CLEAR_N = 40;

   logic       clk = 1'b0;
   logic       rst, lcd_en, lcd_rs, lcd_rw;
   logic [7:0] lcd_data_in, lcd_data_out, rd_char;
   logic       lcd_data_oe, busy, display_on, cursor_on, blink_on, overrun;
   logic [4:0] cursor_pos, rd_addr;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } sb_t;

   sb_t        sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_ram [32];

   always #5 clk = ~clk;

   hd44780_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
      .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
      .busy(busy), .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .cursor_pos(cursor_pos), .overrun(overrun), .rd_addr(rd_addr), .rd_char(rd_char)
   );

   task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [15:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [15:0] obs);
      sb_t e;
      if (sb_q.size() == 0) begin
         compare("scoreboard_empty", 16'd1, 16'd0);
      end else begin
         e = sb_q.pop_front();
         compare(e.tag, obs, e.exp);
      end
   endtask

   task automatic strobe(input logic rs, input logic rw, input logic [7:0] data);
      @(negedge clk);
      lcd_rs      = rs;
      lcd_rw      = rw;
      lcd_data_in = data;
      lcd_en      = 1'b1;
      repeat (3) @(negedge clk);
      lcd_en = 1'b0;
   endtask

   // Strobe, then measure raw-fall-to-busy latency and busy length.
   task automatic write_cmd(input logic rs, input logic [7:0] data, input int busy_len);
      int lat = -1;
      int len = 0;
      sb_push($sformatf("busy_len_%0h_%02h", rs, data), 16'(busy_len));
      strobe(rs, 1'b0, data);
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (busy) begin
            if (lat < 0) lat = k;
            len++;
         end else if (lat >= 0) begin
            break;
         end
      end
      sb_pop(16'(len));
      compare($sformatf("busy_latency_%02h", data), 16'(lat), 16'd3);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) compare("idle_timeout", 16'd1, 16'd0);
   endtask

   task automatic scan_cells(input string tag);
      for (int i = 0; i <= 32; i++) begin
         @(negedge clk);
         if (i > 0) sb_pop(16'(rd_char));
         if (i < 32) begin
            rd_addr = 5'(i);
            sb_push($sformatf("%s_cell%0d", tag, i), 16'(model_ram[i]));
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_ram[i] = 8'h20;
   endtask

`ifdef HD44780_READ_EN
   task automatic read_check(input logic rs, input logic [7:0] exp, input string tag);
      @(negedge clk);
      lcd_rs = rs;
      lcd_rw = 1'b1;
      lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      compare({tag, "_oe"}, 16'(lcd_data_oe), 16'd1);
      compare({tag, "_data"}, 16'(lcd_data_out), 16'(exp));
      lcd_en = 1'b0;
      repeat (3) @(negedge clk);
      lcd_rw = 1'b0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
      lcd_data_in = 8'h00; rd_addr = 5'd0;
      model_reset();
      repeat (3) @(negedge clk);
      compare("rst_busy", 16'(busy), 16'd0);
      compare("rst_display_on", 16'(display_on), 16'd0);
      compare("rst_cursor_on", 16'(cursor_on), 16'd0);
      compare("rst_blink_on", 16'(blink_on), 16'd0);
      compare("rst_overrun", 16'(overrun), 16'd0);
      compare("rst_cursor_pos", 16'(cursor_pos), 16'd0);
      compare("rst_rd_char", 16'(rd_char), 16'h00);
      compare("rst_data_out", 16'(lcd_data_out), 16'h00);
      compare("rst_data_oe", 16'(lcd_data_oe), 16'd0);
      rst = 1'b0;

      // Init sequence and two characters.
      write_cmd(1'b0, 8'h38, BUSY_N);
      write_cmd(1'b0, 8'h0C, BUSY_N);
      write_cmd(1'b0, 8'h06, BUSY_N);
      write_cmd(1'b0, 8'h80, BUSY_N);
      write_cmd(1'b1, 8'h41, BUSY_N); model_ram[0] = 8'h41;
      write_cmd(1'b1, 8'h42, BUSY_N); model_ram[1] = 8'h42;
      compare("init_display_on", 16'(display_on), 16'd1);
      compare("init_cursor_on", 16'(cursor_on), 16'd0);
      compare("init_blink_on", 16'(blink_on), 16'd0);
      compare("init_cursor_pos", 16'(cursor_pos), 16'd2);
      scan_cells("init");

      // Clear after filling a third cell.
      write_cmd(1'b1, 8'h43, BUSY_N); model_ram[2] = 8'h43;
      write_cmd(1'b0, 8'h01, CLEAR_N);
      model_reset();
      compare("clear_cursor_pos", 16'(cursor_pos), 16'd0);
      scan_cells("clear");

      // Row-end behaviour and set-address remapping.
      write_cmd(1'b0, 8'h8F, BUSY_N);
      compare("ac0f_cursor", 16'(cursor_pos), 16'd15);
      write_cmd(1'b1, 8'h58, BUSY_N); model_ram[15] = 8'h58;
      compare("ac10_cursor", 16'(cursor_pos), 16'd31);
      write_cmd(1'b1, 8'h59, BUSY_N);
      compare("ac11_cursor", 16'(cursor_pos), 16'd31);
      write_cmd(1'b0, 8'hA7, BUSY_N);
      compare("ac27_cursor", 16'(cursor_pos), 16'd31);
      write_cmd(1'b1, 8'h5A, BUSY_N);
      compare("wrap27_cursor", 16'(cursor_pos), 16'd16);
      write_cmd(1'b0, 8'hF0, BUSY_N);
      compare("map70_cursor", 16'(cursor_pos), 16'd0);
      write_cmd(1'b0, 8'hB0, BUSY_N);
      compare("map30_cursor", 16'(cursor_pos), 16'd16);

      // Decrement mode across the row boundary.
      write_cmd(1'b0, 8'h04, BUSY_N);
      write_cmd(1'b0, 8'hC0, BUSY_N);
      compare("ac40_cursor", 16'(cursor_pos), 16'd16);
      write_cmd(1'b1, 8'h51, BUSY_N); model_ram[16] = 8'h51;
      compare("dec40_cursor", 16'(cursor_pos), 16'd31);
      write_cmd(1'b0, 8'h06, BUSY_N);
      write_cmd(1'b1, 8'h52, BUSY_N);
      compare("inc27_cursor", 16'(cursor_pos), 16'd16);
      scan_cells("wrap");

      write_cmd(1'b0, 8'h80, BUSY_N);
      write_cmd(1'b1, 8'h41, BUSY_N); model_ram[0] = 8'h41;
      compare("a_cursor", 16'(cursor_pos), 16'd1);
`ifdef HD44780_READ_EN
      strobe(1'b0, 1'b0, 8'h85);
      read_check(1'b0, 8'h85, "read_busy_ac");
      wait_idle();
      write_cmd(1'b0, 8'h80, BUSY_N);
      read_check(1'b1, 8'h41, "read_ddram");
      repeat (2) @(negedge clk);
      compare("read_step_cursor", 16'(cursor_pos), 16'd1);
`else
      write_cmd(1'b0, 8'h80, BUSY_N);
      @(negedge clk);
      lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      compare("noread_oe", 16'(lcd_data_oe), 16'd0);
      compare("noread_data", 16'(lcd_data_out), 16'h00);
      lcd_en = 1'b0;
      repeat (4) @(negedge clk);
      lcd_rw = 1'b0;
      compare("noread_cursor", 16'(cursor_pos), 16'd0);
      compare("noread_busy", 16'(busy), 16'd0);
`endif
      compare("pre_overrun", 16'(overrun), 16'd0);

      // Second strobe during busy is dropped and flagged.
      strobe(1'b0, 1'b0, 8'h0F);
      repeat (2) @(negedge clk);
      strobe(1'b0, 1'b0, 8'h08);
      wait_idle();
      compare("overrun_set", 16'(overrun), 16'd1);
      compare("overrun_display_on", 16'(display_on), 16'd1);
      compare("overrun_cursor_on", 16'(cursor_on), 16'd1);
      compare("overrun_blink_on", 16'(blink_on), 16'd1);

      // Reset partway through clearing.
      strobe(1'b0, 1'b0, 8'h01);
      repeat (8) @(negedge clk);
      compare("midclear_busy", 16'(busy), 16'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      compare("midclear_rst_busy", 16'(busy), 16'd0);
      compare("midclear_rst_overrun", 16'(overrun), 16'd0);
      compare("midclear_rst_display", 16'(display_on), 16'd0);
      model_reset();
      scan_cells("rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
